// File: rtl/rv32i_pkg.sv
// Shared constants and tag type for the unified memory arbiter.
package rv32i_pkg;

    localparam logic MEM_OWNER_IF = 1'b0;
    localparam logic MEM_OWNER_D  = 1'b1;

    localparam logic [3:0] STRB_NONE = 4'b0000;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Fetch, data and memory-side signals of the unified memory arbiter.
interface rv32i_mem_arbiter_if #(
    parameter int ADDR_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr,
        output mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr,
        input  mem_wdata, mem_wstrb,
        output mem_rdata
    );

endinterface

// File: rtl/rv32i_resp_tagpipe.sv
// Read-response tag shift register; one stage per cycle of memory latency.
module rv32i_resp_tagpipe
    import rv32i_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t tag_d [MEM_LAT];
    tag_t tag_q [MEM_LAT];

    always_comb begin
        tag_d[0] = in_tag;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MEM_LAT; i++) begin
            if (reset) begin
                tag_q[i] <= '0;
            end else begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign out_tag = tag_q[MEM_LAT-1];

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store ports;
// data wins, with a bounded fetch wait, and read data is routed by tag.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    rv32i_mem_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_cnt_d;
    logic [3:0]        starve_cnt_q;
    logic              force_if;
    logic              d_gnt;
    logic              if_gnt;
    logic              mem_req_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [31:0]       mem_wdata_d;
    logic [3:0]        mem_wstrb_d;
    tag_t              tag_in;
    tag_t              tag_out;
    logic              if_rvalid;
    logic              d_rvalid;

    // Fetch is forced only once it has watched STARVE_MAX data grants.
    always_comb begin
        force_if = bus.if_req && (starve_cnt_q == STARVE_LIM);
        d_gnt    = !reset && bus.d_req && !force_if;
        if_gnt   = !reset && bus.if_req && !d_gnt;
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.if_req || if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (d_gnt && starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = 32'h0;
        mem_wstrb_d = STRB_NONE;
        unique case (1'b1)
            d_gnt: begin
                mem_req_d   = 1'b1;
                mem_we_d    = bus.d_we;
                mem_addr_d  = bus.d_addr;
                mem_wdata_d = bus.d_wdata;
                mem_wstrb_d = bus.d_we ? bus.d_wstrb : STRB_NONE;
            end
            if_gnt: begin
                mem_req_d  = 1'b1;
                mem_addr_d = bus.if_addr;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        tag_in.valid = mem_req_d && !mem_we_d;
        tag_in.owner = d_gnt ? MEM_OWNER_D : MEM_OWNER_IF;
    end

    rv32i_resp_tagpipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tagpipe (
        .clk     (clk),
        .reset   (reset),
        .in_tag  (tag_in),
        .out_tag (tag_out)
    );

    // Gating on reset hides tags that are cleared only at the next edge.
    always_comb begin
        if_rvalid = !reset && tag_out.valid
                    && (tag_out.owner == MEM_OWNER_IF);
        d_rvalid  = !reset && tag_out.valid
                    && (tag_out.owner == MEM_OWNER_D);
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.d_rdata   = d_rvalid ? bus.mem_rdata : 32'h0;
    assign bus.mem_req   = mem_req_d;
    assign bus.mem_we    = mem_we_d;
    assign bus.mem_addr  = mem_addr_d;
    assign bus.mem_wdata = mem_wdata_d;
    assign bus.mem_wstrb = mem_wstrb_d;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter at MEM_LAT=1 and MEM_LAT=3.
module tb_rv32i_mem_arbiter;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    rv32i_mem_arbiter_if #(.ADDR_W(32)) b1 ();
    rv32i_mem_arbiter_if #(.ADDR_W(32)) b3 ();

    rv32i_mem_arbiter #(
        .ADDR_W(32), .MEM_LAT(1), .STARVE_MAX(4)
    ) u_dut1 (
        .clk(clk), .reset(rst1), .bus(b1.slave)
    );

    rv32i_mem_arbiter #(
        .ADDR_W(32), .MEM_LAT(3), .STARVE_MAX(4)
    ) u_dut3 (
        .clk(clk), .reset(rst3), .bus(b3.slave)
    );

    // Memory models, preloaded while their DUT is in reset.
    logic [31:0] mem1 [0:255];
    logic [31:0] rd1;
    logic [31:0] mem3 [0:255];
    logic [31:0] rp3 [0:2];

    always @(posedge clk) begin
        if (rst1) begin
            mem1[0]  <= 32'h0;
            mem1[4]  <= 32'h00500093;
            mem1[64] <= 32'hDEADBEEF;
        end else if (b1.mem_req && b1.mem_we) begin
            for (int k = 0; k < 4; k++)
                if (b1.mem_wstrb[k])
                    mem1[b1.mem_addr[9:2]][8*k +: 8] <= b1.mem_wdata[8*k +: 8];
        end
        rd1 <= (b1.mem_req && !b1.mem_we) ? mem1[b1.mem_addr[9:2]] : 32'h0;
    end
    assign b1.mem_rdata = rd1;

    always @(posedge clk) begin
        if (rst3) begin
            mem3[8]  <= 32'hA0A0A0A0;
            mem3[9]  <= 32'hB1B1B1B1;
            mem3[10] <= 32'hC2C2C2C2;
            mem3[11] <= 32'h13579BDF;
        end
        rp3[0] <= (b3.mem_req && !b3.mem_we) ? mem3[b3.mem_addr[9:2]] : 32'h0;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign b3.mem_rdata = rp3[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0;
        b1.d_addr = 0; b1.d_wdata = 0; b1.d_wstrb = 0;
    endtask

    task automatic idle3();
        b3.if_req = 0; b3.if_addr = 0; b3.d_req = 0; b3.d_we = 0;
        b3.d_addr = 0; b3.d_wdata = 0; b3.d_wstrb = 0;
    endtask

    task automatic test_reset();
        rst1 = 1; rst3 = 1;
        idle1(); idle3();
        b1.if_req = 1; b1.if_addr = 32'h10;
        b1.d_req = 1; b1.d_addr = 32'h100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec_cnt++; if (b1.if_gnt !== 1'b0) begin err_cnt++; $display("FAIL rst_if_gnt cyc=%0d got=%b exp=0", c, b1.if_gnt); end
            vec_cnt++; if (b1.d_gnt !== 1'b0) begin err_cnt++; $display("FAIL rst_d_gnt cyc=%0d got=%b exp=0", c, b1.d_gnt); end
            vec_cnt++; if (b1.mem_req !== 1'b0) begin err_cnt++; $display("FAIL rst_mem_req cyc=%0d got=%b exp=0", c, b1.mem_req); end
            vec_cnt++; if (b1.if_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_if_rvalid cyc=%0d got=%b exp=0", c, b1.if_rvalid); end
            vec_cnt++; if (b1.d_rvalid !== 1'b0) begin err_cnt++; $display("FAIL rst_d_rvalid cyc=%0d got=%b exp=0", c, b1.d_rvalid); end
            step();
        end
        rst1 = 0;
        idle1();
        @(negedge clk);
        vec_cnt++; if (b1.mem_req !== 1'b0) begin err_cnt++; $display("FAIL post_rst_mem_req got=%b exp=0", b1.mem_req); end
        vec_cnt++; if (b1.if_rvalid !== 1'b0) begin err_cnt++; $display("FAIL post_rst_if_rvalid got=%b exp=0", b1.if_rvalid); end
        vec_cnt++; if (u_dut1.starve_cnt_q !== 4'd0) begin err_cnt++; $display("FAIL post_rst_starve got=%0d exp=0", u_dut1.starve_cnt_q); end
    endtask

    task automatic test_fetch();
        step();
        b1.if_req = 1; b1.if_addr = 32'h10;
        @(negedge clk);
        vec_cnt++; if (b1.if_gnt !== 1'b1) begin err_cnt++; $display("FAIL fetch_gnt got=%b exp=1", b1.if_gnt); end
        vec_cnt++; if (b1.mem_addr !== 32'h10) begin err_cnt++; $display("FAIL fetch_addr got=%h exp=00000010", b1.mem_addr); end
        vec_cnt++; if (b1.mem_wstrb !== 4'h0) begin err_cnt++; $display("FAIL fetch_wstrb got=%h exp=0", b1.mem_wstrb); end
        step();
        b1.if_req = 0;
        @(negedge clk);
        vec_cnt++; if (b1.if_rvalid !== 1'b1) begin err_cnt++; $display("FAIL fetch_rvalid got=%b exp=1", b1.if_rvalid); end
        vec_cnt++; if (b1.if_rdata !== 32'h00500093) begin err_cnt++; $display("FAIL fetch_rdata got=%h exp=00500093", b1.if_rdata); end
        vec_cnt++; if (b1.d_rvalid !== 1'b0) begin err_cnt++; $display("FAIL fetch_d_rvalid got=%b exp=0", b1.d_rvalid); end
        step();
        @(negedge clk);
        vec_cnt++; if (b1.if_rvalid !== 1'b0) begin err_cnt++; $display("FAIL fetch_rvalid_drop got=%b exp=0", b1.if_rvalid); end
        vec_cnt++; if (b1.if_rdata !== 32'h0) begin err_cnt++; $display("FAIL fetch_rdata_zero got=%h exp=0", b1.if_rdata); end
    endtask

    task automatic test_both();
        step();
        b1.if_req = 1; b1.if_addr = 32'h10;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h100;
        @(negedge clk);
        vec_cnt++; if (b1.d_gnt !== 1'b1) begin err_cnt++; $display("FAIL both_d_gnt got=%b exp=1", b1.d_gnt); end
        vec_cnt++; if (b1.if_gnt !== 1'b0) begin err_cnt++; $display("FAIL both_if_gnt got=%b exp=0", b1.if_gnt); end
        vec_cnt++; if (b1.mem_addr !== 32'h100) begin err_cnt++; $display("FAIL both_addr got=%h exp=00000100", b1.mem_addr); end
        step();
        b1.d_req = 0;
        @(negedge clk);
        vec_cnt++; if (b1.if_gnt !== 1'b1) begin err_cnt++; $display("FAIL both_if_gnt2 got=%b exp=1", b1.if_gnt); end
        vec_cnt++; if (b1.d_rvalid !== 1'b1) begin err_cnt++; $display("FAIL both_d_rvalid got=%b exp=1", b1.d_rvalid); end
        vec_cnt++; if (b1.d_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL both_d_rdata got=%h exp=deadbeef", b1.d_rdata); end
        vec_cnt++; if (b1.if_rvalid !== 1'b0) begin err_cnt++; $display("FAIL both_if_rvalid_early got=%b exp=0", b1.if_rvalid); end
        step();
        b1.if_req = 0;
        @(negedge clk);
        vec_cnt++; if (b1.if_rvalid !== 1'b1) begin err_cnt++; $display("FAIL both_if_rvalid got=%b exp=1", b1.if_rvalid); end
        vec_cnt++; if (b1.if_rdata !== 32'h00500093) begin err_cnt++; $display("FAIL both_if_rdata got=%h exp=00500093", b1.if_rdata); end
        vec_cnt++; if (b1.d_rvalid !== 1'b0) begin err_cnt++; $display("FAIL both_d_rvalid_late got=%b exp=0", b1.d_rvalid); end
    endtask

    task automatic test_starvation();
        // Bit i set: fetch wins cycle i.
        logic [9:0] exp_if;
        exp_if = 10'b10_0001_0000;
        step();
        b1.if_req = 1; b1.if_addr = 32'h10;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vec_cnt++; if (b1.if_gnt !== exp_if[c]) begin err_cnt++; $display("FAIL starve_if_gnt cyc=%0d got=%b exp=%b", c, b1.if_gnt, exp_if[c]); end
            vec_cnt++; if (b1.d_gnt !== !exp_if[c]) begin err_cnt++; $display("FAIL starve_d_gnt cyc=%0d got=%b exp=%b", c, b1.d_gnt, !exp_if[c]); end
            if (c > 0) begin
                vec_cnt++; if (b1.if_rvalid !== exp_if[c-1]) begin err_cnt++; $display("FAIL starve_if_rvalid cyc=%0d got=%b exp=%b", c, b1.if_rvalid, exp_if[c-1]); end
                vec_cnt++; if (b1.d_rvalid !== !exp_if[c-1]) begin err_cnt++; $display("FAIL starve_d_rvalid cyc=%0d got=%b exp=%b", c, b1.d_rvalid, !exp_if[c-1]); end
            end
            step();
        end
        b1.if_req = 0; b1.d_req = 0;
        @(negedge clk);
        vec_cnt++; if (b1.if_rvalid !== 1'b1) begin err_cnt++; $display("FAIL starve_last_rvalid got=%b exp=1", b1.if_rvalid); end
        vec_cnt++; if (u_dut1.starve_cnt_q !== 4'd0) begin err_cnt++; $display("FAIL starve_cnt_clear got=%0d exp=0", u_dut1.starve_cnt_q); end
    endtask

    task automatic test_store_load();
        step();
        b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h0;
        b1.d_wdata = 32'h0000000C; b1.d_wstrb = 4'hF;
        @(negedge clk);
        vec_cnt++; if (b1.d_gnt !== 1'b1) begin err_cnt++; $display("FAIL st_gnt got=%b exp=1", b1.d_gnt); end
        vec_cnt++; if (b1.mem_we !== 1'b1) begin err_cnt++; $display("FAIL st_we got=%b exp=1", b1.mem_we); end
        vec_cnt++; if (b1.mem_wstrb !== 4'hF) begin err_cnt++; $display("FAIL st_wstrb got=%h exp=f", b1.mem_wstrb); end
        vec_cnt++; if (b1.mem_wdata !== 32'h0000000C) begin err_cnt++; $display("FAIL st_wdata got=%h exp=0000000c", b1.mem_wdata); end
        step();
        b1.d_req = 0; b1.d_we = 0; b1.d_wstrb = 0; b1.d_wdata = 0;
        @(negedge clk);
        vec_cnt++; if (b1.d_rvalid !== 1'b0) begin err_cnt++; $display("FAIL st_no_rvalid got=%b exp=0", b1.d_rvalid); end
        step();
        b1.d_req = 1; b1.d_addr = 32'h0;
        @(negedge clk);
        vec_cnt++; if (b1.mem_we !== 1'b0) begin err_cnt++; $display("FAIL ld_we got=%b exp=0", b1.mem_we); end
        vec_cnt++; if (b1.mem_wstrb !== 4'h0) begin err_cnt++; $display("FAIL ld_wstrb got=%h exp=0", b1.mem_wstrb); end
        step();
        b1.d_addr = 32'h103;
        @(negedge clk);
        vec_cnt++; if (b1.d_rvalid !== 1'b1) begin err_cnt++; $display("FAIL ld_rvalid got=%b exp=1", b1.d_rvalid); end
        vec_cnt++; if (b1.d_rdata !== 32'h0000000C) begin err_cnt++; $display("FAIL ld_rdata got=%h exp=0000000c", b1.d_rdata); end
        vec_cnt++; if (b1.mem_addr !== 32'h103) begin err_cnt++; $display("FAIL misalign_addr got=%h exp=00000103", b1.mem_addr); end
        step();
        b1.d_req = 0; b1.d_addr = 0;
        @(negedge clk);
        vec_cnt++; if (b1.d_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL misalign_rdata got=%h exp=deadbeef", b1.d_rdata); end
    endtask

    task automatic test_reset_midflight();
        step();
        rst3 = 0;
        idle3();
        step();
        b3.if_req = 1; b3.if_addr = 32'h20;
        @(negedge clk);
        vec_cnt++; if (b3.if_gnt !== 1'b1) begin err_cnt++; $display("FAIL mid_gnt0 got=%b exp=1", b3.if_gnt); end
        step();
        b3.if_req = 0; b3.d_req = 1; b3.d_addr = 32'h24;
        @(negedge clk);
        vec_cnt++; if (b3.d_gnt !== 1'b1) begin err_cnt++; $display("FAIL mid_gnt1 got=%b exp=1", b3.d_gnt); end
        step();
        b3.d_req = 0; b3.if_req = 1; b3.if_addr = 32'h28;
        @(negedge clk);
        vec_cnt++; if (b3.if_gnt !== 1'b1) begin err_cnt++; $display("FAIL mid_gnt2 got=%b exp=1", b3.if_gnt); end
        step();
        idle3();
        rst3 = 1;
        @(negedge clk);
        vec_cnt++; if (b3.if_rvalid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_if_rvalid got=%b exp=0", b3.if_rvalid); end
        vec_cnt++; if (b3.d_rvalid !== 1'b0) begin err_cnt++; $display("FAIL mid_rst_d_rvalid got=%b exp=0", b3.d_rvalid); end
        step();
        rst3 = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vec_cnt++; if (b3.if_rvalid !== 1'b0) begin err_cnt++; $display("FAIL mid_post_if_rvalid cyc=%0d got=%b exp=0", c, b3.if_rvalid); end
            vec_cnt++; if (b3.d_rvalid !== 1'b0) begin err_cnt++; $display("FAIL mid_post_d_rvalid cyc=%0d got=%b exp=0", c, b3.d_rvalid); end
            step();
        end
        b3.if_req = 1; b3.if_addr = 32'h2C;
        @(negedge clk);
        vec_cnt++; if (b3.if_gnt !== 1'b1) begin err_cnt++; $display("FAIL lat3_gnt got=%b exp=1", b3.if_gnt); end
        step();
        idle3();
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            vec_cnt++; if (b3.if_rvalid !== 1'b0) begin err_cnt++; $display("FAIL lat3_early cyc=%0d got=%b exp=0", c, b3.if_rvalid); end
            step();
        end
        @(negedge clk);
        vec_cnt++; if (b3.if_rvalid !== 1'b1) begin err_cnt++; $display("FAIL lat3_rvalid got=%b exp=1", b3.if_rvalid); end
        vec_cnt++; if (b3.if_rdata !== 32'h13579BDF) begin err_cnt++; $display("FAIL lat3_rdata got=%h exp=13579bdf", b3.if_rdata); end
        vec_cnt++; if (b3.d_rvalid !== 1'b0) begin err_cnt++; $display("FAIL lat3_d_rvalid got=%b exp=0", b3.d_rvalid); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_starvation();
        test_store_load();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
